// File: rtl/nios_system_cpu_oci_pkg.sv
// nios_system_cpu_oci_pkg: shared DCT codes, frame types and packer state encoding
package nios_system_cpu_oci_pkg;
    localparam logic [1:0] DCT_CODE_NT = 2'b01;
    localparam logic [1:0] DCT_CODE_TK = 2'b10;
    localparam logic [1:0] FRM_FULL = 2'b01;
    localparam logic [1:0] FRM_PART = 2'b10;
    localparam int FRAME_W = 36;
    typedef enum logic {IDLE, FILL} pk_state_e;
endpackage

// File: rtl/nios_system_cpu_oci_frame_slot.sv
// nios_system_cpu_oci_frame_slot: one-entry valid/ready frame register with drop detection
module nios_system_cpu_oci_frame_slot
    import nios_system_cpu_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               ready,
    input  logic               ovf_clr,
    output logic               valid,
    output logic [FRAME_W-1:0] data,
    output logic               overflow
);
    logic take, ld, drop;
    assign take = valid & ready;
    assign ld = load & (~valid | take);
    assign drop = load & valid & ~ready;
    // slot occupancy, held frame and sticky drop flag (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data <= '0;
            overflow <= 1'b0;
        end else begin
            valid <= ld | (valid & ~take);
            if (ld) data <= load_data;
            overflow <= drop | (overflow & ~ovf_clr);
        end
    end
endmodule

// File: rtl/nios_system_cpu_oci_dct_packer.sv
// nios_system_cpu_oci_dct_packer: packs DCT branch codes into trace frames
module nios_system_cpu_oci_dct_packer
    import nios_system_cpu_oci_pkg::*;
#(
    parameter int DCT_SLOTS = 15,
    parameter int CODE_W = 2,
    parameter int BUF_W = DCT_SLOTS * CODE_W,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trc_on,
    input  logic               dct_valid,
    input  logic [1:0]         dct_code,
    input  logic               flush,
    input  logic               ovf_clr,
    input  logic               frame_ready,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_data,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               overflow
);
    pk_state_e state, state_n;
    logic accept, full, emit;
    logic [1:0] frm_type;
    logic [BUF_W-1:0] sh_ins, sh_n;
    logic [CNT_W-1:0] cnt_ins, cnt_n;
    logic [FRAME_W-1:0] frame;
    assign accept = dct_valid & trc_on & (dct_code == DCT_CODE_NT | dct_code == DCT_CODE_TK);
    assign sh_ins = accept ? {dct_buffer[BUF_W-CODE_W-1:0], dct_code} : dct_buffer;
    assign cnt_ins = dct_count + CNT_W'(accept);
    assign frame = {frm_type, 4'(cnt_ins), 30'(sh_ins)};
    // packer state, shift buffer and code count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dct_buffer <= '0;
            dct_count <= '0;
        end else begin
            state <= state_n;
            dct_buffer <= sh_n;
            dct_count <= cnt_n;
        end
    end
    // insert first, then close the frame on fill or flush; fill wins the type
    always_comb begin
        full = accept && state == FILL && cnt_ins == CNT_W'(DCT_SLOTS);
        emit = full || (flush && cnt_ins != '0);
        frm_type = full ? FRM_FULL : FRM_PART;
        state_n = (emit || cnt_ins == '0) ? IDLE : FILL;
        sh_n = emit ? '0 : sh_ins;
        cnt_n = emit ? '0 : cnt_ins;
    end
    nios_system_cpu_oci_frame_slot u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (emit),
        .load_data (frame),
        .ready     (frame_ready),
        .ovf_clr   (ovf_clr),
        .valid     (frame_valid),
        .data      (frame_data),
        .overflow  (overflow)
    );
endmodule

// File: tb/tb_nios_system_cpu_oci_dct_packer.sv
// tb_nios_system_cpu_oci_dct_packer: scoreboard bench for the DCT packer
module tb_nios_system_cpu_oci_dct_packer;
    import nios_system_cpu_oci_pkg::*;
    logic clk = 0, reset_n = 0, trc_on = 0, dct_valid = 0, flush = 0, ovf_clr = 0, frame_ready = 0;
    logic [1:0] dct_code = 0;
    logic frame_valid, overflow;
    logic [FRAME_W-1:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0] dct_count;
    int checks = 0, errors = 0;
    logic [FRAME_W-1:0] q[$];
    logic [29:0] m_buf = 0;
    int m_cnt = 0;
    logic m_sv = 0, m_ovf = 0;

    nios_system_cpu_oci_dct_packer dut (
        .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .dct_valid(dct_valid),
        .dct_code(dct_code), .flush(flush), .ovf_clr(ovf_clr), .frame_ready(frame_ready),
        .frame_valid(frame_valid), .frame_data(frame_data), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] c, input logic fl);
        logic acc, full, emit, take, dropped;
        logic [29:0] nb;
        int nc;
        dct_valid = v;
        dct_code = c;
        flush = fl;
        acc = v && trc_on && (c == 2'b01 || c == 2'b10);
        nb = acc ? {m_buf[27:0], c} : m_buf;
        nc = m_cnt + (acc ? 1 : 0);
        full = acc && nc == 15;
        emit = full || (fl && nc != 0);
        take = m_sv && frame_ready;
        dropped = 0;
        if (take && q.size() > 0) void'(q.pop_front());
        if (emit) begin
            if (!m_sv || take) q.push_back({full ? 2'b01 : 2'b10, 4'(nc), nb});
            else dropped = 1;
        end
        m_sv = (emit && (!m_sv || take)) || (m_sv && !take);
        m_ovf = dropped ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        m_buf = emit ? '0 : nb;
        m_cnt = emit ? 0 : nc;
        @(posedge clk);
        #1;
        chk("count", 64'(dct_count), 64'(m_cnt));
        chk("buffer", 64'(dct_buffer), 64'(m_buf));
        chk("valid", 64'(frame_valid), 64'(m_sv));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (frame_valid && q.size() > 0) chk("frame", 64'(frame_data), 64'(q[0]));
        dct_valid = 0;
        flush = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(frame_valid), 0);
        chk("rst_data", 64'(frame_data), 0);
        chk("rst_count", 64'(dct_count), 0);
        chk("rst_ovf", 64'(overflow), 0);
        reset_n = 1;
        trc_on = 1;
        frame_ready = 1;
        // full frame of taken codes
        for (int i = 0; i < 15; i++) cyc(1, 2'b10, 0);
        chk("t1_frame", 64'(frame_data), 64'({2'b01, 4'hF, 30'h2AAAAAAA}));
        cyc(0, 0, 0);
        // partial frame on flush
        cyc(1, 2'b01, 0);
        cyc(1, 2'b10, 0);
        cyc(1, 2'b01, 0);
        cyc(0, 0, 1);
        chk("t2_frame", 64'(frame_data), 64'({2'b10, 4'h3, 30'h19}));
        cyc(0, 0, 0);
        // accept and flush together
        for (int i = 0; i < 4; i++) cyc(1, 2'b01, 0);
        cyc(1, 2'b10, 1);
        chk("t3_count", 64'(frame_data[33:30]), 5);
        cyc(0, 0, 0);
        // stalled consumer: second full frame dropped
        frame_ready = 0;
        for (int i = 0; i < 30; i++) cyc(1, (i % 3 == 0) ? 2'b01 : 2'b10, 0);
        chk("t4_ovf", 64'(overflow), 1);
        ovf_clr = 1;
        cyc(0, 0, 0);
        ovf_clr = 0;
        chk("t4_ovf_clr", 64'(overflow), 0);
        frame_ready = 1;
        cyc(0, 0, 0);
        // ignored events
        trc_on = 0;
        for (int i = 0; i < 3; i++) cyc(1, 2'b10, 0);
        trc_on = 1;
        cyc(1, 2'b00, 0);
        cyc(1, 2'b11, 0);
        cyc(0, 0, 1);
        chk("t5_nofrm", 64'(frame_valid), 0);
        // trc_on low still honours flush
        cyc(1, 2'b01, 0);
        trc_on = 0;
        cyc(1, 2'b10, 1);
        trc_on = 1;
        cyc(0, 0, 0);
        // reset mid-frame with a full slot
        frame_ready = 0;
        cyc(1, 2'b01, 0);
        cyc(0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 2'b10, 0);
        chk("t6_pre", 64'(dct_count), 7);
        reset_n = 0;
        #2;
        chk("t6_valid", 64'(frame_valid), 0);
        chk("t6_data", 64'(frame_data), 0);
        chk("t6_buf", 64'(dct_buffer), 0);
        chk("t6_count", 64'(dct_count), 0);
        chk("t6_ovf", 64'(overflow), 0);
        m_buf = 0;
        m_cnt = 0;
        m_sv = 0;
        m_ovf = 0;
        q.delete();
        #2;
        reset_n = 1;
        frame_ready = 1;
        cyc(1, 2'b10, 0);
        chk("t6_first", 64'(dct_count), 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
